// File: rtl/i2c_slave.sv
// I2C target (7-bit address) giving byte access to an external register bank
// through an auto-incrementing 8-bit pointer. SCL/SDA are oversampled by clk.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       sda_oen,
    input  logic       scl_in,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_RX_PTR,
        S_RX_DATA,
        S_RX_ACK,
        S_TX_DATA,
        S_TX_ACK,
        S_WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;

    state_t      state;
    state_t      state_n;
    logic [3:0]  bit_cnt;
    logic [3:0]  bit_cnt_n;
    logic [7:0]  rx_sr;
    logic [7:0]  rx_sr_n;
    logic [7:0]  tx_sr;
    logic [7:0]  tx_sr_n;
    logic        rw;
    logic        rw_n;
    logic [7:0]  ptr_n;
    logic [7:0]  wdata_n;
    logic        we_n;
    logic        oen_n;
    logic        busy_n;

    // Bus pins idle high, so the synchronizers reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge value of its neighbour, forming a true shift chain.
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = ~sda_s & sda_prev & scl_s;
    assign stop_det  = sda_s & ~sda_prev & scl_s;

    assign sda_out = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            bit_cnt   <= 4'd0;
            rx_sr     <= 8'h00;
            tx_sr     <= 8'h00;
            rw        <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            sda_oen   <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            rx_sr     <= rx_sr_n;
            tx_sr     <= tx_sr_n;
            rw        <= rw_n;
            reg_addr  <= ptr_n;
            reg_wdata <= wdata_n;
            reg_we    <= we_n;
            sda_oen   <= oen_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first; a path that leaves
        // one unassigned would infer a latch.
        state_n   = state;
        bit_cnt_n = bit_cnt;
        rx_sr_n   = rx_sr;
        tx_sr_n   = tx_sr;
        rw_n      = rw;
        ptr_n     = reg_we ? reg_addr + 8'd1 : reg_addr;
        wdata_n   = reg_wdata;
        we_n      = 1'b0;
        reg_re    = 1'b0;
        oen_n     = sda_oen;
        busy_n    = busy;

        if (start_det) begin
            state_n   = S_ADDR;
            bit_cnt_n = 4'd0;
            oen_n     = 1'b1;
        end else if (stop_det) begin
            state_n = S_IDLE;
            oen_n   = 1'b1;
            busy_n  = 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_WAIT_STOP: ;

                S_ADDR: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        rx_sr_n   = {rx_sr[6:0], sda_s};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        if (rx_sr[7:1] == SLAVE_ADDR) begin
                            state_n = S_ADDR_ACK;
                            oen_n   = 1'b0;
                            busy_n  = 1'b1;
                            rw_n    = rx_sr[0];
                        end else begin
                            state_n = S_WAIT_STOP;
                            oen_n   = 1'b1;
                            busy_n  = 1'b0;
                        end
                    end
                end

                // The fall ending the ACK either hands SDA back or starts driving read data.
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_n = 4'd0;
                        if (rw) begin
                            state_n = S_TX_DATA;
                            reg_re  = 1'b1;
                            tx_sr_n = reg_rdata;
                            oen_n   = reg_rdata[7];
                        end else begin
                            state_n = S_RX_PTR;
                            oen_n   = 1'b1;
                        end
                    end
                end

                S_RX_PTR, S_RX_DATA: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        rx_sr_n   = {rx_sr[6:0], sda_s};
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (state == S_RX_DATA && bit_cnt == 4'd7) begin
                            we_n    = 1'b1;
                            wdata_n = {rx_sr[6:0], sda_s};
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        state_n = S_RX_ACK;
                        oen_n   = 1'b0;
                        if (state == S_RX_PTR) begin
                            ptr_n = rx_sr;
                        end
                    end
                end

                S_RX_ACK: begin
                    if (scl_fall) begin
                        state_n   = S_RX_DATA;
                        bit_cnt_n = 4'd0;
                        oen_n     = 1'b1;
                    end
                end

                S_TX_DATA: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        state_n   = S_TX_ACK;
                        bit_cnt_n = 4'd0;
                        oen_n     = 1'b1;
                    end else if (scl_fall && bit_cnt != 4'd0) begin
                        tx_sr_n = {tx_sr[6:0], 1'b0};
                        oen_n   = tx_sr[6];
                    end
                end

                // bit_cnt==1 marks a master ACK seen on the rise; the pointer moves
                // there so reg_rdata is already valid for the reload on the fall.
                S_TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_n = S_WAIT_STOP;
                        end else begin
                            ptr_n     = reg_addr + 8'd1;
                            bit_cnt_n = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        state_n   = S_TX_DATA;
                        bit_cnt_n = 4'd0;
                        reg_re    = 1'b1;
                        tx_sr_n   = reg_rdata;
                        oen_n     = reg_rdata[7];
                    end
                end

                default: state_n = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged I2C master plus a transaction-level model of
// the register pointer, write stream and read stream.
module tb_i2c_slave;

    localparam logic [6:0] SADDR = 7'h50;
    localparam int         Q     = 6;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       sda_m = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_in;
    logic       sda_out;
    logic       sda_oen;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;

    logic [7:0] bank [256];

    assign sda_in    = sda_m & (sda_oen | sda_out);
    assign reg_rdata = bank[reg_addr];

    i2c_slave #(.SLAVE_ADDR(SADDR), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .sda_in   (sda_in),
        .sda_out  (sda_out),
        .sda_oen  (sda_oen),
        .scl_in   (scl_m),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_rdata(reg_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: the pointer the design should hold and the strobes it owes us.
    logic [7:0]  model_ptr = 8'h00;
    logic [15:0] exp_we_q[$];
    logic [7:0]  exp_re_q[$];
    logic [15:0] wlog[$];
    int          re_cnt      = 0;
    int          sda_low_cnt = 0;
    logic [7:0]  wbuf [8];
    logic [7:0]  rbuf [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model's strobe queues and bus rules.
    logic       prev_oen   = 1'b1;
    logic       we_pending = 1'b0;
    logic [7:0] we_addr    = 8'h00;

    always @(negedge clk) begin
        logic [15:0] ew;
        logic [7:0]  ea;
        check("sda_out_const", 32'(sda_out), 32'd0);
        check("we_re_exclusive", 32'(reg_we & reg_re), 32'd0);
        if (!sda_oen) sda_low_cnt++;
        if (prev_oen && !sda_oen) check("sda_drive_only_scl_low", 32'(scl_m), 32'd0);
        prev_oen = sda_oen;
        if (we_pending) check("ptr_inc_after_we", 32'(reg_addr), 32'(8'(we_addr + 8'd1)));
        we_pending = 1'b0;
        if (reg_we) begin
            wlog.push_back({reg_addr, reg_wdata});
            n_cmp++;
            if (exp_we_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_reg_we: got addr %0h data %0h, expected none", reg_addr, reg_wdata);
            end else begin
                ew = exp_we_q.pop_front();
                check("reg_we_addr", 32'(reg_addr), 32'(ew[15:8]));
                check("reg_we_data", 32'(reg_wdata), 32'(ew[7:0]));
            end
            we_pending = 1'b1;
            we_addr    = reg_addr;
        end
        if (reg_re) begin
            re_cnt++;
            n_cmp++;
            if (exp_re_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_reg_re: got addr %0h, expected none", reg_addr);
            end else begin
                ea = exp_re_q.pop_front();
                check("reg_re_addr", 32'(reg_addr), 32'(ea));
            end
        end
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic clock_bit(input logic b, output logic r);
        sda_m = b;    wait_q();
        scl_m = 1'b1; wait_q();
        r = sda_in;   wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
        clock_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, r);
            d[i] = r;
        end
        clock_bit(mack, r);
    endtask

    // Write transaction: wbuf[0] is the pointer, the rest are data bytes.
    task automatic do_write(input logic [6:0] a, input int n, input logic do_stop);
        logic ack;
        logic match;
        match = (a == SADDR);
        bus_start();
        send_byte({a, 1'b0}, ack);
        check("w_addr_ack", 32'(ack), 32'(!match));
        check("w_busy_after_addr", 32'(busy), 32'(match));
        for (int k = 0; k < n; k++) begin
            if (match) begin
                if (k == 0) begin
                    model_ptr = wbuf[0];
                end else begin
                    exp_we_q.push_back({model_ptr, wbuf[k]});
                    model_ptr = model_ptr + 8'd1;
                end
            end
            send_byte(wbuf[k], ack);
            check("w_data_ack", 32'(ack), 32'(!match));
        end
        if (do_stop) begin
            bus_stop();
            check("w_busy_after_stop", 32'(busy), 32'd0);
            check("w_ptr_after_stop", 32'(reg_addr), 32'(model_ptr));
        end
    endtask

    // Read transaction of n bytes from the current pointer; last byte is NACKed.
    task automatic do_read(input logic [6:0] a, input int n);
        logic       ack;
        logic       match;
        logic [7:0] d;
        match = (a == SADDR);
        if (match) for (int k = 0; k < n; k++) exp_re_q.push_back(8'(model_ptr + 8'(k)));
        bus_start();
        send_byte({a, 1'b1}, ack);
        check("r_addr_ack", 32'(ack), 32'(!match));
        check("r_busy_after_addr", 32'(busy), 32'(match));
        if (match) begin
            for (int k = 0; k < n; k++) begin
                recv_byte(k == n - 1, d);
                rbuf[k] = d;
                check("r_data", 32'(d), 32'(bank[model_ptr]));
                if (k < n - 1) model_ptr = model_ptr + 8'd1;
            end
        end
        bus_stop();
        check("r_busy_after_stop", 32'(busy), 32'd0);
        check("r_sda_released", 32'(sda_oen), 32'd1);
        check("r_ptr_after_stop", 32'(reg_addr), 32'(model_ptr));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sda_oen"}, 32'(sda_oen), 32'd1);
        check({tag, "_sda_out"}, 32'(sda_out), 32'd0);
        check({tag, "_reg_addr"}, 32'(reg_addr), 32'd0);
        check({tag, "_reg_wdata"}, 32'(reg_wdata), 32'd0);
        check({tag, "_reg_we"}, 32'(reg_we), 32'd0);
        check({tag, "_reg_re"}, 32'(reg_re), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       r;
        logic       ack;
        int         re0;
        int         kind;
        int         n;
        logic [6:0] a;

        for (int i = 0; i < 256; i++) bank[i] = 8'($urandom);

        repeat (4) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Basic write: pointer 0x10, two data bytes.
        wlog.delete();
        wbuf[0] = 8'h10; wbuf[1] = 8'h5A; wbuf[2] = 8'hC3;
        do_write(SADDR, 3, 1'b1);
        check("wr_log_size", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            check("wr_log0", 32'(wlog[0]), 32'h105A);
            check("wr_log1", 32'(wlog[1]), 32'h11C3);
        end
        check("wr_final_ptr", 32'(reg_addr), 32'h12);
        check("wr_model_ptr", 32'(model_ptr), 32'h12);

        // Pointer write, repeated START, two-byte read.
        bank[8'h20] = 8'h33;
        bank[8'h21] = 8'h44;
        re0 = re_cnt;
        wbuf[0] = 8'h20;
        do_write(SADDR, 1, 1'b0);
        do_read(SADDR, 2);
        check("rd_byte0", 32'(rbuf[0]), 32'h33);
        check("rd_byte1", 32'(rbuf[1]), 32'h44);
        check("rd_re_pulses", 32'(re_cnt - re0), 32'd2);

        // Address mismatch (0xA2) and general call are both NACKed silently.
        wlog.delete();
        sda_low_cnt = 0;
        wbuf[0] = 8'h11;
        do_write(7'h51, 1, 1'b1);
        do_write(7'h00, 1, 1'b1);
        check("mm_sda_never_low", 32'(sda_low_cnt), 32'd0);
        check("mm_no_we", 32'(wlog.size()), 32'd0);

        // Pointer wrap.
        wlog.delete();
        wbuf[0] = 8'hFF; wbuf[1] = 8'h01; wbuf[2] = 8'h02;
        do_write(SADDR, 3, 1'b1);
        check("wrap_log_size", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            check("wrap_log0", 32'(wlog[0]), 32'hFF01);
            check("wrap_log1", 32'(wlog[1]), 32'h0002);
        end
        check("wrap_final_ptr", 32'(reg_addr), 32'h01);

        // STOP after 4 data bits, then START after 3 data bits: partial bytes vanish.
        wlog.delete();
        bus_start();
        send_byte({SADDR, 1'b0}, ack);
        send_byte(8'h30, ack);
        model_ptr = 8'h30;
        for (int i = 0; i < 4; i++) clock_bit(i[0], r);
        bus_stop();
        check("abort_stop_no_we", 32'(wlog.size()), 32'd0);
        check("abort_stop_ptr", 32'(reg_addr), 32'h30);
        check("abort_stop_busy", 32'(busy), 32'd0);
        bus_start();
        send_byte({SADDR, 1'b0}, ack);
        send_byte(8'h31, ack);
        model_ptr = 8'h31;
        for (int i = 0; i < 3; i++) clock_bit(1'b0, r);
        wbuf[0] = 8'h40; wbuf[1] = 8'h77;
        do_write(SADDR, 2, 1'b1);
        check("abort_start_log_size", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) check("abort_start_log0", 32'(wlog[0]), 32'h4077);

        // Randomized transactions against the model.
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    n = $urandom_range(1, 4);
                    for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
                    do_write(SADDR, n, 1'b1);
                end
                1: do_read(SADDR, $urandom_range(1, 3));
                2: begin
                    wbuf[0] = 8'($urandom);
                    do_write(SADDR, 1, 1'b0);
                    do_read(SADDR, $urandom_range(1, 3));
                end
                default: begin
                    a = 7'($urandom_range(0, 127));
                    if (a == SADDR) a = a ^ 7'h01;
                    wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
                    if ($urandom_range(0, 1) == 0) do_write(a, 2, 1'b1);
                    else do_read(a, 1);
                end
            endcase
        end

        // Reset while the target is driving a 0 bit of read data.
        bank[8'h40] = 8'h00;
        wbuf[0] = 8'h40;
        do_write(SADDR, 1, 1'b0);
        exp_re_q.push_back(8'h40);
        bus_start();
        send_byte({SADDR, 1'b1}, ack);
        check("rr_addr_ack", 32'(ack), 32'd0);
        clock_bit(1'b1, r);
        clock_bit(1'b1, r);
        check("rr_sda_driven_low", 32'(sda_oen), 32'd0);
        #2 reset = 1'b0;
        #1 check_reset_outputs("rr_async");
        repeat (3) @(negedge clk);
        check_reset_outputs("rr_held");
        reset = 1'b1;
        model_ptr = 8'h00;
        for (int i = 0; i < 7; i++) begin
            clock_bit(1'b1, r);
            check("rr_ignore_bus", 32'(r), 32'd1);
        end
        bus_stop();
        check("rr_busy", 32'(busy), 32'd0);
        check("rr_ptr", 32'(reg_addr), 32'd0);
        wbuf[0] = 8'h05; wbuf[1] = 8'hAA;
        do_write(SADDR, 2, 1'b1);

        repeat (4) @(negedge clk);
        check("we_queue_drained", 32'(exp_we_q.size()), 32'd0);
        check("re_queue_drained", 32'(exp_re_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
